// File: rtl/fib_seq_regfile_engine_if.sv
// Bus bundle for fib_seq_regfile_engine: run request, operands, debug
// readback and status. The master (harness) drives the request side and the
// slave (engine) drives the status side.
//
// Handshake: start is a level request that is only looked at while the
// engine is idle. It is accepted on the first rising clk edge where
// start=1 and state is IDLE. busy stays high from LOAD through COMPUTE.
// done is a single-cycle pulse in DONE. result and carry_flag are then
// stable until the next accepted start. Holding start high while busy has
// no effect.
interface fib_seq_regfile_engine_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16
);
  localparam int AW = $clog2(NUM_REGS);

  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_flag;
  logic [AW-1:0]    step;
  logic [1:0]       state_dbg;

  modport master (
    output start, mode, seed0, seed1, rd_addr,
    input  rd_data, busy, done, result, carry_flag, step, state_dbg
  );

  modport slave (
    input  start, mode, seed0, seed1, rd_addr,
    output rd_data, busy, done, result, carry_flag, step, state_dbg
  );
endinterface

// File: rtl/fib_seq_regfile_engine.sv
// fib_seq_regfile_engine: seeds R0/R1, then fills R2..R(N-1) one register
// per cycle with R[i] = op(R[i-2], R[i-1]), and reports R(N-1) plus a
// sticky carry/borrow flag.
//
// Optional build macro FIB_SATURATE_EN: when it is defined, ADD and ADDC
// results clamp to all-ones on carry-out, and SUB results clamp to zero on
// borrow. The ADDC carry chain still follows the raw carry-out.
module fib_seq_regfile_engine #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  fib_seq_regfile_engine_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0] M_ADD  = 2'b00;
  localparam logic [1:0] M_ADDC = 2'b01;
  localparam logic [1:0] M_SUB  = 2'b10;
  localparam logic [1:0] M_XOR  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] seed0_q, seed0_d;
  logic [WIDTH-1:0] seed1_q, seed1_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [AW-1:0]    step_q, step_d;
  logic             carry_flag_q, carry_flag_d;
  logic             cin_q, cin_d;

  // ALU operands are the two registers just below the one being written
  logic [AW-1:0]    idx_a, idx_b;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   sum_w, diff_w;
  logic             cin_use;
  logic [WIDTH-1:0] alu_raw, alu_res;
  logic             alu_cout;

  // Operand fetch and ALU for the current COMPUTE step
  always_comb begin
    idx_a   = step_q - AW'(2);
    idx_b   = step_q - AW'(1);
    op_a    = (int'(idx_a) < NUM_REGS) ? regs_q[idx_a] : '0;
    op_b    = (int'(idx_b) < NUM_REGS) ? regs_q[idx_b] : '0;
    cin_use = (mode_q == M_ADDC) ? cin_q : 1'b0;
    sum_w   = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin_use};
    diff_w  = {1'b0, op_a} - {1'b0, op_b};
    alu_raw  = '0;
    alu_cout = 1'b0;
    case (mode_q)
      M_ADD, M_ADDC: begin
        alu_raw  = sum_w[WIDTH-1:0];
        alu_cout = sum_w[WIDTH];
      end
      M_SUB: begin
        alu_raw  = diff_w[WIDTH-1:0];
        alu_cout = diff_w[WIDTH];
      end
      M_XOR: begin
        alu_raw  = op_a ^ op_b;
        alu_cout = 1'b0;
      end
      default: begin
        alu_raw  = '0;
        alu_cout = 1'b0;
      end
    endcase
    alu_res = alu_raw;
`ifdef FIB_SATURATE_EN
    if (alu_cout) begin
      alu_res = (mode_q == M_SUB) ? '0 : '1;
    end
`else
`endif
  end

  // Sequencer next-state: capture, load seeds, step through registers
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    seed0_d      = seed0_q;
    seed1_d      = seed1_q;
    regs_d       = regs_q;
    result_d     = result_q;
    step_d       = step_q;
    carry_flag_d = carry_flag_q;
    cin_d        = cin_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d       = bus.mode;
          seed0_d      = bus.seed0;
          seed1_d      = bus.seed1;
          carry_flag_d = 1'b0;
          cin_d        = 1'b0;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        regs_d[0] = seed0_q;
        regs_d[1] = seed1_q;
        step_d    = AW'(2);
        state_d   = S_COMPUTE;
      end
      S_COMPUTE: begin
        regs_d[step_q] = alu_res;
        cin_d          = alu_cout;
        if (alu_cout) begin
          carry_flag_d = 1'b1;
        end
        if (int'(step_q) == NUM_REGS - 1) begin
          result_d = alu_res;
          step_d   = '0;
          state_d  = S_DONE;
        end else begin
          step_d = step_q + AW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Debug readback samples the register file every cycle
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, bus.rd_addr} < (AW+1)'(NUM_REGS)) begin
      rd_data_d = regs_q[bus.rd_addr];
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      seed0_q      <= '0;
      seed1_q      <= '0;
      rd_data_q    <= '0;
      result_q     <= '0;
      step_q       <= '0;
      carry_flag_q <= 1'b0;
      cin_q        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      seed0_q      <= seed0_d;
      seed1_q      <= seed1_d;
      rd_data_q    <= rd_data_d;
      result_q     <= result_d;
      step_q       <= step_d;
      carry_flag_q <= carry_flag_d;
      cin_q        <= cin_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_COMPUTE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.rd_data    = rd_data_q;
  assign bus.result     = result_q;
  assign bus.carry_flag = carry_flag_q;
  assign bus.step       = step_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_fib_seq_regfile_engine.sv
// Bench for fib_seq_regfile_engine: a 16-bit and an 8-bit instance (both
// N=16) share one stimulus stream. Directed runs are checked against
// hand-computed register values.
module tb_fib_seq_regfile_engine;
  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] seed0;
  logic [15:0] seed1;
  logic [3:0]  rd_addr;

  int total = 0;
  int bad   = 0;

  fib_seq_regfile_engine_if #(.WIDTH(16), .NUM_REGS(16)) bus16 ();
  fib_seq_regfile_engine_if #(.WIDTH(8),  .NUM_REGS(16)) bus8 ();

  assign bus16.start   = start;
  assign bus16.mode    = mode;
  assign bus16.seed0   = seed0;
  assign bus16.seed1   = seed1;
  assign bus16.rd_addr = rd_addr;
  assign bus8.start    = start;
  assign bus8.mode     = mode;
  assign bus8.seed0    = seed0[7:0];
  assign bus8.seed1    = seed1[7:0];
  assign bus8.rd_addr  = rd_addr;

  fib_seq_regfile_engine #(.WIDTH(16), .NUM_REGS(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave)
  );
  fib_seq_regfile_engine #(.WIDTH(8), .NUM_REGS(16)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected values that depend on the saturation build option
`ifdef FIB_SATURATE_EN
  localparam logic [7:0]  E8_ADD_R13  = 8'd255;
  localparam logic [7:0]  E8_ADD_R14  = 8'd255;
  localparam logic [7:0]  E8_ADD_RES  = 8'd255;
  localparam logic [7:0]  E8_ADDC_R13 = 8'd255;
  localparam logic [7:0]  E8_ADDC_R14 = 8'd255;
  localparam logic [7:0]  E8_ADDC_RES = 8'd255;
  localparam logic [15:0] E16_SUB_R7  = 16'h0000;
`else
  localparam logic [7:0]  E8_ADD_R13  = 8'd121;
  localparam logic [7:0]  E8_ADD_R14  = 8'd98;
  localparam logic [7:0]  E8_ADD_RES  = 8'd219;
  localparam logic [7:0]  E8_ADDC_R13 = 8'd121;
  localparam logic [7:0]  E8_ADDC_R14 = 8'd99;
  localparam logic [7:0]  E8_ADDC_RES = 8'd221;
  localparam logic [15:0] E16_SUB_R7  = 16'hFFFF;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: request a run, then count edges until done (bounded)
  task automatic run(input logic [1:0] m, input logic [15:0] s0, input logic [15:0] s1,
                     output int lat, output logic seen);
    @(negedge clk);
    mode  = m;
    seed0 = s0;
    seed1 = s1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", {31'd0, bus16.busy}, 32'd1);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus16.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("done8_same_cycle", {31'd0, bus8.done}, 32'd1);
  endtask

  // driver: readback through the registered debug port
  task automatic readback(input logic [3:0] addr, output logic [15:0] r16, output logic [7:0] r8);
    @(negedge clk);
    rd_addr = addr;
    @(posedge clk);
    #1;
    r16 = bus16.rd_data;
    r8  = bus8.rd_data;
  endtask

  // bounded wait for a given step value on the 16-bit instance
  task automatic wait_step(input logic [3:0] s, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus16.step == s) begin
        hit = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  logic [15:0] exp_sub [6] = '{16'd2, 16'd1, 16'd1, 16'd0, 16'd1, 16'h0000};

  initial begin
    int          lat;
    logic        seen;
    logic [15:0] r16;
    logic [7:0]  r8;
    int          done_count;

    exp_sub[5] = E16_SUB_R7;
    reset   = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    seed0   = '0;
    seed1   = '0;
    rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   {31'd0, bus16.busy}, 32'd0);
    check("rst_done",   {31'd0, bus16.done}, 32'd0);
    check("rst_result", {16'd0, bus16.result}, 32'd0);
    check("rst_carry",  {31'd0, bus16.carry_flag}, 32'd0);
    check("rst_step",   {28'd0, bus16.step}, 32'd0);
    check("rst_rdata",  {16'd0, bus16.rd_data}, 32'd0);
    check("rst_state",  {30'd0, bus16.state_dbg}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ADD 1,1: 16-bit Fibonacci to 987, 8-bit wraps
    run(2'b00, 16'd1, 16'd1, lat, seen);
    check("add_latency", lat, 32'd15);
    check("add_result16", {16'd0, bus16.result}, 32'h03DB);
    check("add_carry16",  {31'd0, bus16.carry_flag}, 32'd0);
    check("add_result8",  {24'd0, bus8.result}, {24'd0, E8_ADD_RES});
    check("add_carry8",   {31'd0, bus8.carry_flag}, 32'd1);
    check("done_step0",   {28'd0, bus16.step}, 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, bus16.done}, 32'd0);
    check("idle_not_busy",  {31'd0, bus16.busy}, 32'd0);
    check("result_hold",    {16'd0, bus16.result}, 32'h03DB);
    readback(4'd7, r16, r8);
    check("add_r7_16", {16'd0, r16}, 32'h0015);
    readback(4'd13, r16, r8);
    check("add_r13_8", {24'd0, r8}, {24'd0, E8_ADD_R13});
    readback(4'd14, r16, r8);
    check("add_r14_8", {24'd0, r8}, {24'd0, E8_ADD_R14});

    // ADDC 1,1: carry chains into the following step on the 8-bit unit
    run(2'b01, 16'd1, 16'd1, lat, seen);
    check("addc_result8",  {24'd0, bus8.result}, {24'd0, E8_ADDC_RES});
    check("addc_carry8",   {31'd0, bus8.carry_flag}, 32'd1);
    check("addc_result16", {16'd0, bus16.result}, 32'h03DB);
    check("addc_carry16",  {31'd0, bus16.carry_flag}, 32'd0);
    readback(4'd13, r16, r8);
    check("addc_r13_8", {24'd0, r8}, {24'd0, E8_ADDC_R13});
    readback(4'd14, r16, r8);
    check("addc_r14_8", {24'd0, r8}, {24'd0, E8_ADDC_R14});

    // XOR 0x00F0,0x000F: period-3 pattern FF,F0,0F
    run(2'b11, 16'h00F0, 16'h000F, lat, seen);
    check("xor_result16", {16'd0, bus16.result}, 32'h00F0);
    check("xor_carry16",  {31'd0, bus16.carry_flag}, 32'd0);
    readback(4'd2, r16, r8);
    check("xor_r2", {16'd0, r16}, 32'h00FF);
    readback(4'd3, r16, r8);
    check("xor_r3", {16'd0, r16}, 32'h00F0);

    // SUB 5,3: borrow at R7
    run(2'b10, 16'd5, 16'd3, lat, seen);
    check("sub_carry16", {31'd0, bus16.carry_flag}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      readback(4'(i + 2), r16, r8);
      check($sformatf("sub_r%0d", i + 2), {16'd0, r16}, {16'd0, exp_sub[i]});
    end

    // start during COMPUTE is ignored; the run finishes on its own seeds
    @(negedge clk);
    mode  = 2'b00;
    seed0 = 16'd1;
    seed1 = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_step(4'd6, "reach_step6");
    @(negedge clk);
    mode  = 2'b11;
    seed0 = 16'd7;
    seed1 = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus16.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("ignore_done_seen", {31'd0, seen}, 32'd1);
    check("ignore_result", {16'd0, bus16.result}, 32'h03DB);
    check("ignore_carry",  {31'd0, bus16.carry_flag}, 32'd0);
    @(posedge clk);
    #1;
    check("ignore_no_restart", {31'd0, bus16.busy}, 32'd0);

    // reset mid-COMPUTE aborts with no done pulse and clears everything
    @(negedge clk);
    mode  = 2'b00;
    seed0 = 16'd1;
    seed1 = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_step(4'd8, "reach_step8");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy",   {31'd0, bus16.busy}, 32'd0);
    check("abort_done",   {31'd0, bus16.done}, 32'd0);
    check("abort_result", {16'd0, bus16.result}, 32'd0);
    check("abort_state",  {30'd0, bus16.state_dbg}, 32'd0);
    check("abort_step",   {28'd0, bus16.step}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_count = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus16.done || bus8.done) done_count++;
    end
    check("abort_no_done", done_count, 32'd0);
    for (int i = 0; i < 16; i++) begin
      readback(4'(i), r16, r8);
      check($sformatf("abort_r%0d", i), {8'd0, r8, r16}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
